// File: rtl/mc_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and the memories (slave).
// Addresses and requests flow out of the sequencer; acks and fetched data flow back in.
interface mc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer for an RV32I datapath on variable-latency memories.
// Owns PC and instruction register, gates write-back and tracks retires, timeouts and traps.
module mc_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_sequencer_if.master    bus_io,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_four_o,
  input  logic              pc_sel_i,
  input  logic [ADDR_W-1:0] alu_data_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              reg_wr_en_dec_i,
  output logic              rf_wr_en_o,
  output logic              insn_vld_o,
  output logic [ADDR_W-1:0] pc_debug_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_pc_o
);

  localparam logic [31:0] Nop       = 32'h0000_0013;
  localparam logic [31:0] TimeoutM1 = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       wait_q, wait_d;
  logic              insn_vld_q, insn_vld_d;
  logic [ADDR_W-1:0] pc_debug_q, pc_debug_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_pc_q, err_pc_d;

  logic              imem_req, dmem_req, dmem_we, rf_wr_en;
  logic [ADDR_W-1:0] pc_four;
  logic              misaligned;
  logic              timeout_hit;

  assign pc_four     = pc_q + ADDR_W'(4);
  assign misaligned  = pc_sel_i && (alu_data_i[1:0] != 2'b00);
  // Ack in the same cycle as the final wait cycle is checked first, so it wins.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TimeoutM1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wait_d       = wait_q;
    insn_vld_d   = 1'b0;
    pc_debug_d   = pc_debug_q;
    retire_cnt_d = retire_cnt_q;
    err_d        = err_q;
    err_pc_d     = err_pc_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_wr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        wait_d  = '0;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (bus_io.imem_ack) begin
          instr_d = bus_io.imem_rdata;
          state_d = StExec;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          err_pc_d = pc_q;
          state_d  = StErr;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      StExec: begin
        if (is_load_i || is_store_i) begin
          state_d = StMem;
          wait_d  = '0;
        end else if (misaligned) begin
          err_d    = 1'b1;
          err_pc_d = pc_q;
          state_d  = StErr;
        end else begin
          rf_wr_en     = reg_wr_en_dec_i;
          pc_d         = pc_sel_i ? alu_data_i : pc_four;
          insn_vld_d   = 1'b1;
          pc_debug_d   = pc_q;
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
          state_d      = StFetch;
          wait_d       = '0;
        end
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store_i;
        if (bus_io.dmem_ack) begin
          if (misaligned) begin
            err_d    = 1'b1;
            err_pc_d = pc_q;
            state_d  = StErr;
          end else begin
            rf_wr_en     = reg_wr_en_dec_i && is_load_i;
            pc_d         = pc_four;
            insn_vld_d   = 1'b1;
            pc_debug_d   = pc_q;
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
            state_d      = StFetch;
            wait_d       = '0;
          end
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          err_pc_d = pc_q;
          state_d  = StErr;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      StErr: begin
        state_d = StErr;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= Nop;
      wait_q       <= '0;
      insn_vld_q   <= 1'b0;
      pc_debug_q   <= '0;
      retire_cnt_q <= '0;
      err_q        <= 1'b0;
      err_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wait_q       <= wait_d;
      insn_vld_q   <= insn_vld_d;
      pc_debug_q   <= pc_debug_d;
      retire_cnt_q <= retire_cnt_d;
      err_q        <= err_d;
      err_pc_q     <= err_pc_d;
    end
  end

  assign bus_io.imem_req  = imem_req;
  assign bus_io.imem_addr = pc_q;
  assign bus_io.dmem_req  = dmem_req;
  assign bus_io.dmem_we   = dmem_we;

  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign pc_four_o    = pc_four;
  assign rf_wr_en_o   = rf_wr_en;
  assign insn_vld_o   = insn_vld_q;
  assign pc_debug_o   = pc_debug_q;
  assign retire_cnt_o = retire_cnt_q;
  assign err_o        = err_q;
  assign err_pc_o     = err_pc_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed scenarios plus a randomized program checked against
// an instruction-level model of PC, retire count and debug outputs.
module tb_mc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] alu_data;
  logic        is_load;
  logic        is_store;
  logic        reg_wr_en_dec;

  logic [31:0] instr, pc, pc_four, pc_debug, retire_cnt, err_pc;
  logic        rf_wr_en, insn_vld, err;
  logic [31:0] t_instr, t_pc, t_pc_four, t_pc_debug, t_retire_cnt, t_err_pc;
  logic        t_rf_wr_en, t_insn_vld, t_err;

  int checks = 0;
  int errors = 0;

  // Instruction-level model state
  logic [31:0] m_pc, m_cnt, m_dbg;

  mc_sequencer_if #(.ADDR_W(32)) bus ();
  mc_sequencer_if #(.ADDR_W(32)) tbus ();

  mc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_io          (bus.master),
    .instr_o         (instr),
    .pc_o            (pc),
    .pc_four_o       (pc_four),
    .pc_sel_i        (pc_sel),
    .alu_data_i      (alu_data),
    .is_load_i       (is_load),
    .is_store_i      (is_store),
    .reg_wr_en_dec_i (reg_wr_en_dec),
    .rf_wr_en_o      (rf_wr_en),
    .insn_vld_o      (insn_vld),
    .pc_debug_o      (pc_debug),
    .retire_cnt_o    (retire_cnt),
    .err_o           (err),
    .err_pc_o        (err_pc)
  );

  mc_sequencer #(.TIMEOUT(4)) dut_t (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_io          (tbus.master),
    .instr_o         (t_instr),
    .pc_o            (t_pc),
    .pc_four_o       (t_pc_four),
    .pc_sel_i        (pc_sel),
    .alu_data_i      (alu_data),
    .is_load_i       (is_load),
    .is_store_i      (is_store),
    .reg_wr_en_dec_i (reg_wr_en_dec),
    .rf_wr_en_o      (t_rf_wr_en),
    .insn_vld_o      (t_insn_vld),
    .pc_debug_o      (t_pc_debug),
    .retire_cnt_o    (t_retire_cnt),
    .err_o           (t_err),
    .err_pc_o        (t_err_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    pc_sel = 0; alu_data = 0; is_load = 0; is_store = 0; reg_wr_en_dec = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.dmem_ack = 0;
    tbus.imem_ack = 0; tbus.imem_rdata = 0; tbus.dmem_ack = 0;
  endtask

  // Leaves both DUTs in their first FETCH cycle, 1 time unit after the edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 32'h0; m_cnt = 0; m_dbg = 0;
    @(posedge clk); #1;
  endtask

  // kind: 0 alu, 1 branch/jump, 2 load, 3 store. Starts and ends in FETCH at edge+1.
  task automatic run_insn(input int kind, input int fw, input int mw, input bit wen,
                          input logic [31:0] target, input logic [31:0] word);
    logic mem;
    mem = (kind >= 2);
    for (int i = 0; i <= fw; i++) begin
      bus.imem_ack = (i == fw); bus.imem_rdata = word; #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++;
        $display("FAIL fetch_req got %b want 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== m_pc) begin errors++;
        $display("FAIL fetch_addr got %h want %h", bus.imem_addr, m_pc); end
      checks++; if (pc_four !== m_pc + 32'd4) begin errors++;
        $display("FAIL pc_four got %h want %h", pc_four, m_pc + 32'd4); end
      checks++; if (bus.dmem_req !== 1'b0 || rf_wr_en !== 1'b0) begin errors++;
        $display("FAIL fetch_quiet got %b%b want 00", bus.dmem_req, rf_wr_en); end
      if (i > 0) begin
        checks++; if (insn_vld !== 1'b0) begin errors++;
          $display("FAIL fetch_vld got %b want 0", insn_vld); end
      end
      @(posedge clk); #1;
    end
    bus.imem_ack = 0;
    checks++; if (instr !== word) begin errors++;
      $display("FAIL instr_latch got %h want %h", instr, word); end
    is_load = (kind == 2); is_store = (kind == 3); pc_sel = (kind == 1);
    alu_data = target; reg_wr_en_dec = wen; #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || insn_vld !== 1'b0) begin
      errors++; $display("FAIL exec_quiet got %b%b%b want 000", bus.imem_req, bus.dmem_req,
                         insn_vld); end
    checks++; if (rf_wr_en !== (mem ? 1'b0 : wen)) begin errors++;
      $display("FAIL exec_wr got %b want %b", rf_wr_en, mem ? 1'b0 : wen); end
    @(posedge clk); #1;
    if (mem) begin
      for (int j = 0; j <= mw; j++) begin
        bus.dmem_ack = (j == mw); #1;
        checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== (kind == 3)) begin errors++;
          $display("FAIL mem_req got %b%b want 1%b", bus.dmem_req, bus.dmem_we, kind == 3); end
        checks++; if (rf_wr_en !== ((j == mw) && wen && kind == 2)) begin errors++;
          $display("FAIL mem_wr got %b want %b", rf_wr_en, (j == mw) && wen && kind == 2); end
        checks++; if (pc !== m_pc) begin errors++;
          $display("FAIL mem_pc got %h want %h", pc, m_pc); end
        @(posedge clk); #1;
      end
      bus.dmem_ack = 0;
    end
    m_dbg = m_pc;
    m_cnt = m_cnt + 1;
    m_pc  = (kind == 1) ? target : m_pc + 32'd4;
    is_load = 0; is_store = 0; pc_sel = 0; reg_wr_en_dec = 0;
    checks++; if (insn_vld !== 1'b1) begin errors++;
      $display("FAIL retire_vld got %b want 1", insn_vld); end
    checks++; if (pc !== m_pc) begin errors++;
      $display("FAIL next_pc got %h want %h", pc, m_pc); end
    checks++; if (pc_debug !== m_dbg) begin errors++;
      $display("FAIL pc_debug got %h want %h", pc_debug, m_dbg); end
    checks++; if (retire_cnt !== m_cnt) begin errors++;
      $display("FAIL retire_cnt got %0d want %0d", retire_cnt, m_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk); #1;
    checks++; if (pc !== 32'h0 || instr !== 32'h13) begin errors++;
      $display("FAIL reset_pc_instr got %h %h want 0 13", pc, instr); end
    checks++; if ({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_wr_en, insn_vld, err} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got %b want 0",
        {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_wr_en, insn_vld, err}); end
    checks++; if (pc_debug !== 0 || retire_cnt !== 0 || err_pc !== 0) begin errors++;
      $display("FAIL reset_regs got %h %h %h want 0", pc_debug, retire_cnt, err_pc); end
    rst_n = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL idle_req got %b want 0", bus.imem_req); end
    @(posedge clk); #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++;
      $display("FAIL first_req got %b want 1", bus.imem_req); end
    m_pc = 0; m_cnt = 0; m_dbg = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) run_insn(0, 0, 0, 1'b1, 32'h0, 32'h0010_0093 + 32'(k) * 32'h10_0000);
    checks++; if (retire_cnt !== 32'd3 || pc_debug !== 32'h8) begin errors++;
      $display("FAIL b2b_summary got %0d %h want 3 8", retire_cnt, pc_debug); end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    run_insn(0, 5, 0, 1'b1, 32'h0, 32'h0050_0113);
  endtask

  task automatic test_load_store();
    do_reset();
    run_insn(2, 0, 2, 1'b1, 32'h100, 32'h0000_2183);
    run_insn(3, 0, 2, 1'b1, 32'h104, 32'h0030_2023);
    checks++; if (pc !== 32'h8) begin errors++;
      $display("FAIL ldst_pc got %h want 8", pc); end
  endtask

  task automatic test_misaligned();
    do_reset();
    run_insn(1, 0, 0, 1'b0, 32'h20, 32'h0200_0063);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0e20_00ef;
    @(posedge clk); #1;
    bus.imem_ack = 0; pc_sel = 1; alu_data = 32'h102; reg_wr_en_dec = 1; #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++;
      $display("FAIL mis_wr got %b want 0", rf_wr_en); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b1 || err_pc !== 32'h20) begin errors++;
      $display("FAIL mis_err got %b %h want 1 20", err, err_pc); end
    checks++; if (insn_vld !== 1'b0 || retire_cnt !== 32'd1 || pc !== 32'h20) begin errors++;
      $display("FAIL mis_noretire got %b %0d %h want 0 1 20", insn_vld, retire_cnt, pc); end
    bus.imem_ack = 1; bus.dmem_ack = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if ({bus.imem_req, bus.dmem_req, rf_wr_en, insn_vld} !== 4'b0) begin errors++;
        $display("FAIL err_quiet got %b want 0",
                 {bus.imem_req, bus.dmem_req, rf_wr_en, insn_vld}); end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      tbus.imem_ack = 1; tbus.imem_rdata = 32'h0000_2083;
      @(posedge clk); #1;
      tbus.imem_ack = 0; is_load = 1; reg_wr_en_dec = 1;
      @(posedge clk); #1;
      for (int c = 1; c <= 4; c++) begin
        tbus.dmem_ack = (v == 1 && c == 4); #1;
        checks++; if (t_err !== 1'b0 || tbus.dmem_req !== 1'b1) begin errors++;
          $display("FAIL to_wait%0d got %b%b want 01", c, t_err, tbus.dmem_req); end
        @(posedge clk); #1;
      end
      tbus.dmem_ack = 0; is_load = 0; reg_wr_en_dec = 0;
      checks++; if (t_err !== (v == 0) || t_retire_cnt !== 32'(v)) begin errors++;
        $display("FAIL to_result%0d got %b %0d want %b %0d", v, t_err, t_retire_cnt, v == 0, v);
      end
      checks++; if (t_pc !== (v == 0 ? 32'h0 : 32'h4) || t_err_pc !== 32'h0) begin errors++;
        $display("FAIL to_pc%0d got %h %h", v, t_pc, t_err_pc); end
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run_insn(0, 0, 0, 1'b1, 32'h0, 32'h0010_0093);
    run_insn(0, 0, 0, 1'b1, 32'h0, 32'h0010_0093);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0020_2223;
    @(posedge clk); #1;
    bus.imem_ack = 0; is_store = 1;
    @(posedge clk); #1;
    checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin errors++;
      $display("FAIL pre_rst_mem got %b%b want 11", bus.dmem_req, bus.dmem_we); end
    #2 rst_n = 1'b0; #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req got %b%b%b want 000", bus.dmem_req, bus.dmem_we,
                         bus.imem_req); end
    checks++; if (pc !== 0 || instr !== 32'h13 || pc_debug !== 0 || retire_cnt !== 0) begin
      errors++; $display("FAIL rst_mid_regs got %h %h %h %h want 0 13 0 0", pc, instr, pc_debug,
                         retire_cnt); end
    clear_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_dbg = 0;
    @(posedge clk); #1;
    run_insn(0, 0, 0, 1'b1, 32'h0, 32'h0010_0093);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      run_insn(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
               $urandom & 32'hFFFF_FFFC, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fetch_wait();
    test_load_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
